// File: rtl/qpsk_bit_packer.sv
// QPSK symbol demapper, sync-word hunter and byte packer with a small output FIFO.
// Optional differential decoding is enabled by defining DIFF_DECODE_EN.
module qpsk_bit_packer #(
  parameter logic [15:0] SYNC_WORD   = 16'h1ACF,
  parameter int          FRAME_BYTES = 8,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic       clk_fs,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] bit_in_I,
  input  logic [1:0] bit_in_Q,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       locked,
  output logic       overflow,
  output logic       erasure
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCK   = 1'b1;

  logic [0:0]       state;
  // Only the bits that can still reach the next 16-bit compare are kept.
  logic [13:0]      sreg;
  logic [15:0]      sreg_next;
  logic [5:0]       acc;
  logic [2:0]       bit_cnt;
  logic [7:0]       byte_cnt;
  logic [7:0]       byte_new;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic i_bit;
  logic q_bit;
  logic byte_done;
  logic full;
  logic pop;
  logic push;

`ifdef DIFF_DECODE_EN
  logic prev_i;
  logic prev_q;

  always_ff @(posedge clk_fs) begin
    if (rst) begin
      prev_i <= 1'b0;
      prev_q <= 1'b0;
    end else if (sym_valid) begin
      prev_i <= bit_in_I[1];
      prev_q <= bit_in_Q[1];
    end
  end

  assign i_bit = bit_in_I[1] ^ prev_i;
  assign q_bit = bit_in_Q[1] ^ prev_q;
`else
  assign i_bit = bit_in_I[1];
  assign q_bit = bit_in_Q[1];
`endif

  assign sreg_next = {sreg, i_bit, q_bit};
  assign byte_new  = {acc, i_bit, q_bit};
  assign byte_done = sym_valid && (state == LOCK) && (bit_cnt == 3'd6);

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign byte_valid = (count != '0);
  assign pop        = byte_valid && byte_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push       = byte_done && (!full || pop);

  assign byte_out = byte_valid ? mem[rd_ptr] : 8'h00;
  assign locked   = (state == LOCK);

  always_ff @(posedge clk_fs) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state    <= SEARCH;
      sreg     <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      if (sym_valid) sreg <= sreg_next[13:0];
      case (state)
        SEARCH: begin
          bit_cnt  <= '0;
          byte_cnt <= '0;
          if (sym_valid && (sreg_next == SYNC_WORD)) state <= LOCK;
        end
        LOCK: begin
          if (sym_valid) begin
            acc <= {acc[3:0], i_bit, q_bit};
            if (bit_cnt == 3'd6) begin
              bit_cnt  <= '0;
              byte_cnt <= byte_cnt + 8'd1;
              if (byte_cnt == LAST_BYTE) state <= SEARCH;
            end else begin
              bit_cnt <= bit_cnt + 3'd2;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  // NOTE: the FIFO storage is deliberately left out of reset; byte_out is
  // masked by byte_valid, so stale entries are never observable.
  always_ff @(posedge clk_fs) begin
    if (push) mem[wr_ptr] <= byte_new;
  end

  always_ff @(posedge clk_fs) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      erasure  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (byte_done && full && !pop) overflow <= 1'b1;
      erasure <= sym_valid && (!bit_in_I[0] || !bit_in_Q[0]);
    end
  end

endmodule
